// File: rtl/operand_feeder.sv
// Operand feeder: buffers up to DEPTH operands, then streams them to one
// edge input of a systolic MAC cell using the waiting/ready/finished
// handshake. An optional SKEW delay after start aligns this row/column
// with its neighbours in the array.
module operand_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int SKEW       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    input  logic [DATA_WIDTH-1:0]        load_data,
    output logic                         load_ready,
    input  logic                         start,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         out_waiting,
    input  logic                         out_ready,
    output logic                         out_finished,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW          = $clog2(DEPTH + 1);
    localparam int AW          = $clog2(DEPTH);
    localparam int SKEW_LAST_I = (SKEW > 0) ? (SKEW - 1) : 0;
    localparam logic [7:0]    SKEW_LAST = 8'(SKEW_LAST_I);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SKEW    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_FINISH  = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          count_r;
    logic [AW-1:0]          rd_r;
    logic [7:0]             skew_r;
    logic [DATA_WIDTH-1:0]  buffer_r [DEPTH];

    logic                   load_ready_r;
    logic                   busy_r;
    logic                   out_waiting_r;
    logic                   out_finished_r;
    logic [DATA_WIDTH-1:0]  data_out_r;

    state_t                 state_nxt_s;
    logic [CW-1:0]          count_nxt_s;
    logic [CW-1:0]          count_ld_s;
    logic [AW-1:0]          rd_nxt_s;
    logic [7:0]             skew_nxt_s;
    logic                   load_fire_s;
    logic [DATA_WIDTH-1:0]  present_word_s;

    assign load_ready   = load_ready_r;
    assign busy         = busy_r;
    assign out_waiting  = out_waiting_r;
    assign out_finished = out_finished_r;
    assign data_out     = data_out_r;
    assign count        = count_r;

    // Next-state logic: loads, start decision, skew countdown, handshake progress.
    always_comb begin
        load_fire_s = (state_r == ST_IDLE) && load_valid && load_ready_r;
        count_ld_s  = count_r + CW'(load_fire_s);
        state_nxt_s = state_r;
        count_nxt_s = count_ld_s;
        rd_nxt_s    = rd_r;
        skew_nxt_s  = skew_r;
        case (state_r)
            ST_IDLE: begin
                // A word loaded in the start cycle counts toward the stream.
                if (start && (count_ld_s != {CW{1'b0}})) begin
                    rd_nxt_s   = {AW{1'b0}};
                    skew_nxt_s = 8'd0;
                    if (SKEW > 0) begin
                        state_nxt_s = ST_SKEW;
                    end else begin
                        state_nxt_s = ST_PRESENT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SKEW: begin
                if (skew_r == SKEW_LAST) begin
                    skew_nxt_s  = 8'd0;
                    state_nxt_s = ST_PRESENT;
                end else begin
                    skew_nxt_s  = skew_r + 8'd1;
                end
            end
            ST_PRESENT: begin
                if (out_waiting_r && out_ready) begin
                    if (CW'(rd_r) == (count_r - CW'(1))) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        rd_nxt_s = rd_r + AW'(1);
                    end
                end else begin
                    state_nxt_s = ST_PRESENT;
                end
            end
            ST_FINISH: begin
                if (out_ready) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FINISH;
                end
            end
            ST_DRAIN: begin
                // One release cycle, then the buffer is considered empty.
                state_nxt_s = ST_IDLE;
                count_nxt_s = {CW{1'b0}};
                rd_nxt_s    = {AW{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = {CW{1'b0}};
                rd_nxt_s    = {AW{1'b0}};
                skew_nxt_s  = 8'd0;
            end
        endcase
    end

    // Word to present next; bypasses the buffer when it is being written this cycle.
    always_comb begin
        if (load_fire_s && (CW'(rd_nxt_s) == count_r)) begin
            present_word_s = load_data;
        end else begin
            present_word_s = buffer_r[rd_nxt_s];
        end
    end

    // Operand storage; contents are meaningful only below count.
    always_ff @(posedge clk) begin
        if (rst && load_fire_s) begin
            buffer_r[AW'(count_r)] <= load_data;
        end
    end

    // FSM state and registered outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            count_r        <= {CW{1'b0}};
            rd_r           <= {AW{1'b0}};
            skew_r         <= 8'd0;
            load_ready_r   <= 1'b0;
            busy_r         <= 1'b0;
            out_waiting_r  <= 1'b0;
            out_finished_r <= 1'b0;
            data_out_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            count_r        <= count_nxt_s;
            rd_r           <= rd_nxt_s;
            skew_r         <= skew_nxt_s;
            load_ready_r   <= (state_nxt_s == ST_IDLE) && (count_nxt_s < DEPTH_C);
            busy_r         <= (state_nxt_s != ST_IDLE);
            out_waiting_r  <= (state_nxt_s == ST_PRESENT) || (state_nxt_s == ST_DRAIN);
            out_finished_r <= (state_nxt_s == ST_FINISH);
            data_out_r     <= (state_nxt_s == ST_PRESENT) ? present_word_s
                                                          : {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: two instances (SKEW=0 and SKEW=4) share one
// stimulus stream and are each compared every cycle to a queue-style model.
module tb_operand_feeder;

    localparam int P_IDLE    = 0;
    localparam int P_WAIT    = 1;
    localparam int P_STREAM  = 2;
    localparam int P_END     = 3;
    localparam int P_RELEASE = 4;

    logic        clk = 1'b0;
    logic        rst, load_valid, start, out_ready;
    logic [31:0] load_data;

    logic        lr0, ow0, of0, busy0;
    logic [31:0] do0;
    logic [3:0]  cnt0;
    logic        lr4, ow4, of4, busy4;
    logic [31:0] do4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = SKEW 0 instance, 1 = SKEW 4 instance
    int          mskew  [2];
    int          mphase [2];
    int          mleft  [2];
    int          midx   [2];
    int          msize  [2];
    logic [31:0] mbuf   [2][8];
    logic [31:0] e_data [2];
    logic        e_ow   [2];
    logic        e_of   [2];
    logic        e_busy [2];
    logic        e_lr   [2];

    typedef struct {
        logic        rst, lv;
        logic [31:0] ld;
        logic        st, ordy;
        logic [31:0] x_data;
        logic        x_ow, x_of, x_busy;
        logic [3:0]  x_cnt;
        logic        x_lr;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    operand_feeder #(.DATA_WIDTH(32), .DEPTH(8), .SKEW(0)) u_dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(lr0), .start(start), .data_out(do0), .out_waiting(ow0),
        .out_ready(out_ready), .out_finished(of0), .busy(busy0), .count(cnt0));

    operand_feeder #(.DATA_WIDTH(32), .DEPTH(8), .SKEW(4)) u_dut4 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(lr4), .start(start), .data_out(do4), .out_waiting(ow4),
        .out_ready(out_ready), .out_finished(of4), .busy(busy4), .count(cnt4));

    function automatic vec_t mk(logic r, logic lv, logic [31:0] ld, logic st, logic ordy,
                                logic [31:0] xd, logic xow, logic xof, logic xb,
                                logic [3:0] xc, logic xlr);
        vec_t v;
        v.rst = r; v.lv = lv; v.ld = ld; v.st = st; v.ordy = ordy;
        v.x_data = xd; v.x_ow = xow; v.x_of = xof; v.x_busy = xb;
        v.x_cnt = xc; v.x_lr = xlr;
        return v;
    endfunction

    // Advance one model by one clock edge using the current inputs.
    task automatic model_step(input int m);
        if (!rst) begin
            mphase[m] = P_IDLE; msize[m] = 0; midx[m] = 0; mleft[m] = 0;
        end else begin
            case (mphase[m])
                P_IDLE: begin
                    if (load_valid && e_lr[m]) begin
                        mbuf[m][msize[m]] = load_data;
                        msize[m]++;
                    end
                    if (start && msize[m] > 0) begin
                        midx[m] = 0;
                        if (mskew[m] > 0) begin
                            mphase[m] = P_WAIT;
                            mleft[m]  = mskew[m];
                        end else begin
                            mphase[m] = P_STREAM;
                        end
                    end
                end
                P_WAIT: begin
                    mleft[m]--;
                    if (mleft[m] == 0) mphase[m] = P_STREAM;
                end
                P_STREAM: if (out_ready) begin
                    midx[m]++;
                    if (midx[m] == msize[m]) mphase[m] = P_END;
                end
                P_END: if (out_ready) mphase[m] = P_RELEASE;
                default: begin
                    mphase[m] = P_IDLE;
                    msize[m]  = 0;
                end
            endcase
        end
        e_lr[m]   = rst && (mphase[m] == P_IDLE) && (msize[m] < 8);
        e_ow[m]   = (mphase[m] == P_STREAM) || (mphase[m] == P_RELEASE);
        e_of[m]   = (mphase[m] == P_END);
        e_busy[m] = (mphase[m] != P_IDLE);
        e_data[m] = (mphase[m] == P_STREAM) ? mbuf[m][midx[m]] : 32'd0;
    endtask

    task automatic check_inst(input int m);
        logic [31:0] ad;
        logic        aow, aof, ab, alr;
        logic [3:0]  ac;
        if (m == 0) begin
            ad = do0; aow = ow0; aof = of0; ab = busy0; ac = cnt0; alr = lr0;
        end else begin
            ad = do4; aow = ow4; aof = of4; ab = busy4; ac = cnt4; alr = lr4;
        end
        checks++;
        if ({ad, aow, aof, ab, ac, alr} !== {e_data[m], e_ow[m], e_of[m], e_busy[m],
                                             4'(msize[m]), e_lr[m]}) begin
            errors++;
            $display("FAIL model dut%0d t=%0t: got data=%h wait=%b fin=%b busy=%b cnt=%0d rdy=%b, expected data=%h wait=%b fin=%b busy=%b cnt=%0d rdy=%b",
                     m, $time, ad, aow, aof, ab, ac, alr,
                     e_data[m], e_ow[m], e_of[m], e_busy[m], msize[m], e_lr[m]);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] xp);
        checks++;
        if (act !== xp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, xp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_inst(0);
        check_inst(1);
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        load_valid = 1'b0; start = 1'b0; out_ready = 1'b1; rst = 1'b1;
        while ((e_busy[0] || e_busy[1]) && n < 60) begin
            tick();
            n++;
        end
        chk("drain bound", 32'(n < 60), 32'd1);
    endtask

    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1; load_data = w; start = 1'b0;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        int n;
        mskew[0] = 0; mskew[1] = 4;
        for (int m = 0; m < 2; m++) begin
            mphase[m] = P_IDLE; msize[m] = 0; midx[m] = 0; mleft[m] = 0;
            e_lr[m] = 1'b0; e_ow[m] = 1'b0; e_of[m] = 1'b0; e_busy[m] = 1'b0;
            e_data[m] = 32'd0;
        end
        rst = 1'b0; load_valid = 1'b0; load_data = 32'd0; start = 1'b0; out_ready = 1'b0;

        // basic stream 3,5,7 on the SKEW=0 instance, with ignored starts
        tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(1, 1, 3, 0, 0,  0, 0, 0, 0, 1, 1);
        tbl[4]  = mk(1, 1, 5, 0, 0,  0, 0, 0, 0, 2, 1);
        tbl[5]  = mk(1, 1, 7, 0, 0,  0, 0, 0, 0, 3, 1);
        tbl[6]  = mk(1, 0, 0, 1, 1,  3, 1, 0, 1, 3, 0);
        tbl[7]  = mk(1, 0, 0, 1, 1,  5, 1, 0, 1, 3, 0);
        tbl[8]  = mk(1, 0, 0, 0, 1,  7, 1, 0, 1, 3, 0);
        tbl[9]  = mk(1, 0, 0, 0, 1,  0, 0, 1, 1, 3, 0);
        tbl[10] = mk(1, 0, 0, 0, 1,  0, 1, 0, 1, 3, 0);
        tbl[11] = mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; load_valid = tbl[i].lv; load_data = tbl[i].ld;
            start = tbl[i].st; out_ready = tbl[i].ordy;
            tick();
            checks++;
            if ({do0, ow0, of0, busy0, cnt0, lr0} !==
                {tbl[i].x_data, tbl[i].x_ow, tbl[i].x_of, tbl[i].x_busy, tbl[i].x_cnt, tbl[i].x_lr}) begin
                errors++;
                $display("FAIL table row %0d: got data=%h wait=%b fin=%b busy=%b cnt=%0d rdy=%b, expected data=%h wait=%b fin=%b busy=%b cnt=%0d rdy=%b",
                         i, do0, ow0, of0, busy0, cnt0, lr0, tbl[i].x_data, tbl[i].x_ow,
                         tbl[i].x_of, tbl[i].x_busy, tbl[i].x_cnt, tbl[i].x_lr);
            end
        end
        run_until_idle();

        // skew latency: single word 9 on the SKEW=4 instance
        load_word(32'd9);
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        chk("skew no early wait", 32'(ow4), 32'd0);
        while (ow4 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("skew latency", 32'(n), 32'd5);
        chk("skew first word", do4, 32'd9);
        run_until_idle();

        // full buffer: 8 loads, 9th dropped
        for (int i = 0; i < 8; i++) load_word(32'h100 + 32'(i));
        chk("full count", 32'(cnt0), 32'd8);
        chk("full ready low", 32'(lr0), 32'd0);
        load_valid = 1'b1; load_data = 32'hdead;
        tick();
        load_valid = 1'b0;
        chk("ninth dropped", 32'(cnt0), 32'd8);
        start = 1'b1; out_ready = 1'b1;
        tick();
        run_until_idle();

        // backpressure on word 4 of stream 2,4
        load_word(32'd2);
        load_word(32'd4);
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("bp first", do0, 32'd2);
        tick();
        chk("bp second", do0, 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp hold data", do0, 32'd4);
            chk("bp hold wait", 32'(ow0), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp finish", 32'(of0), 32'd1);
        run_until_idle();

        // reset mid-stream, then a fresh one-word stream
        for (int i = 0; i < 5; i++) load_word(32'h10 + 32'(i));
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre-reset word2", do0, 32'h11);
        rst = 1'b0;
        tick();
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst count", 32'(cnt0), 32'd0);
        chk("rst data", do0, 32'd0);
        chk("rst wait", 32'(ow0), 32'd0);
        rst = 1'b1;
        tick();
        load_word(32'h55);
        start = 1'b1;
        tick();
        chk("post-reset word", do0, 32'h55);
        run_until_idle();

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 199) != 0);
            load_valid = $urandom_range(0, 1) == 1;
            load_data  = $urandom;
            start      = ($urandom_range(0, 7) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        run_until_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
